// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : opcode, shift and mode encodings plus FSM states for alu_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  localparam logic [1:0] MODE_ALU = 2'd0;
  localparam logic [1:0] MODE_MUL = 2'd1;
  localparam logic [1:0] MODE_MLA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // TST/TEQ/CMP/CMN only set flags, never write back
  function automatic logic is_test(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pipe_if : operand/result handshake bundle of alu_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             cin;
  logic             vin;
  logic [2:0]       shift_op;
  logic [SHW-1:0]   shift_num;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             nout;
  logic             zout;
  logic             cout;
  logic             vout;
  logic             wr;
  logic             err;

  modport master (
    output in_valid, mode, op, a, b, c, cin, vin, shift_op, shift_num, out_ready,
    input  in_ready, out_valid, out, nout, zout, cout, vout, wr, err
  );

  modport slave (
    input  in_valid, mode, op, a, b, c, cin, vin, shift_op, shift_num, out_ready,
    output in_ready, out_valid, out, nout, zout, cout, vout, wr, err
  );
endinterface
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_shifter : ARM operand-2 shifter (LSL/LSR/ASR/ROR/RRX) with carry-out
// Rev 1.0
// ---------------------------------------------------------------------------
module barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 8
) (
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       shift_op,
  input  logic [SHW-1:0]   shift_num,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             err
);

  logic [31:0]             w_n;
  logic [31:0]             w_rot;
  logic [WIDTH:0]          w_lsl;
  logic [WIDTH:0]          w_lsr;
  logic signed [WIDTH:0]   w_asr_in;
  logic signed [WIDTH:0]   w_asr;
  logic [WIDTH-1:0]        w_ror;

  // One extra bit beside the operand catches the last bit shifted out,
  // which is exactly the ARM carry for every amount including n >= WIDTH.
  assign w_n      = 32'(shift_num);
  assign w_rot    = w_n % WIDTH;
  assign w_lsl    = {1'b0, b} << w_n;
  assign w_lsr    = {b, 1'b0} >> w_n;
  assign w_asr_in = {b, 1'b0};
  assign w_asr    = w_asr_in >>> w_n;
  assign w_ror    = WIDTH'({b, b} >> w_rot);

  always_comb begin
    value = b;
    carry = cin;
    err   = 1'b0;
    case (shift_op)
      SH_LSL: if (shift_num != '0) begin
        value = w_lsl[WIDTH-1:0];
        carry = w_lsl[WIDTH];
      end
      SH_LSR: if (shift_num != '0) begin
        value = w_lsr[WIDTH:1];
        carry = w_lsr[0];
      end
      SH_ASR: if (shift_num != '0) begin
        value = w_asr[WIDTH:1];
        carry = w_asr[0];
      end
      SH_ROR: if (shift_num != '0) begin
        value = w_ror;
        carry = w_ror[WIDTH-1];
      end
      SH_RRX: begin
        value = {cin, b[WIDTH-1:1]};
        carry = b[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pipe : 2-stage valid/ready ARM ALU with shifter, flags and shift-add MUL/MLA
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHW    = 8,
  parameter int MUL_EN = 1
) (
  input  logic       CP,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;

  logic             r_s1_v, r_s1_shc, r_s1_cin, r_s1_vin, r_s1_err;
  logic [1:0]       r_s1_mode;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_s1_c;

  logic             r_s2_v, r_s2_n, r_s2_z, r_s2_c, r_s2_v_flag, r_s2_wr, r_s2_err;
  logic [WIDTH-1:0] r_s2_out;

  logic [WIDTH-1:0] w_sh_val;
  logic             w_sh_c, w_sh_err;
  logic             w_in_mulmode, w_in_err, w_in_mul;
  logic             w_s1_adv, w_s1_move, w_s1_mul, w_in_ready, w_accept;

  logic [WIDTH-1:0] w_res, w_x, w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_ci, w_arith, w_c, w_v, w_wr;

  barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .b         (bus.b),
    .cin       (bus.cin),
    .shift_op  (bus.shift_op),
    .shift_num (bus.shift_num),
    .value     (w_sh_val),
    .carry     (w_sh_c),
    .err       (w_sh_err)
  );

  assign w_in_mulmode = (bus.mode == MODE_MUL) || (bus.mode == MODE_MLA);
  assign w_in_err     = w_sh_err || !(w_in_mulmode || bus.mode == MODE_ALU) ||
                        (w_in_mulmode && (MUL_EN == 0));
  assign w_in_mul     = w_in_mulmode && !w_in_err;

  // A multiply occupies stage 1 until the FSM reaches DONE
  assign w_s1_adv   = !r_s2_v || bus.out_ready;
  assign w_s1_move  = r_s1_v && w_s1_adv && (r_state != MUL);
  assign w_s1_mul   = ((r_s1_mode == MODE_MUL) || (r_s1_mode == MODE_MLA)) && !r_s1_err;
  assign w_in_ready = !reset && (r_state == IDLE) && (!r_s1_v || w_s1_adv);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_in_mul) w_state_nx = MUL;
      MUL:     if (r_cnt == CW'(WIDTH - 1)) w_state_nx = DONE;
      DONE:    if (w_s1_move) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == MUL)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Stage 1 doubles as the multiply datapath: a = multiplicand,
  // b = multiplier, c = accumulator (preloaded with 0 or the MLA addend).
  always_ff @(posedge CP) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_c    <= '0;
      r_s1_shc  <= 1'b0;
      r_s1_op   <= '0;
      r_s1_mode <= '0;
      r_s1_cin  <= 1'b0;
      r_s1_vin  <= 1'b0;
      r_s1_err  <= 1'b0;
    end else if (w_accept) begin
      r_s1_v    <= 1'b1;
      r_s1_a    <= bus.a;
      r_s1_b    <= w_sh_val;
      r_s1_c    <= (w_in_mul && (bus.mode == MODE_MUL)) ? '0 : bus.c;
      r_s1_shc  <= w_sh_c;
      r_s1_op   <= bus.op;
      r_s1_mode <= bus.mode;
      r_s1_cin  <= bus.cin;
      r_s1_vin  <= bus.vin;
      r_s1_err  <= w_in_err;
    end else begin
      if (w_s1_move)
        r_s1_v <= 1'b0;
      if (r_state == MUL) begin
        if (r_s1_b[0])
          r_s1_c <= r_s1_c + r_s1_a;
        r_s1_a <= r_s1_a << 1;
        r_s1_b <= r_s1_b >> 1;
      end
    end
  end

  always_comb begin
    w_res   = '0;
    w_x     = '0;
    w_y     = '0;
    w_ci    = 1'b0;
    w_arith = 1'b0;
    w_c     = r_s1_shc;
    w_v     = r_s1_vin;
    w_wr    = !is_test(r_s1_op);
    case (r_s1_op)
      OP_AND, OP_TST: w_res = r_s1_a & r_s1_b;
      OP_EOR, OP_TEQ: w_res = r_s1_a ^ r_s1_b;
      OP_ORR:         w_res = r_s1_a | r_s1_b;
      OP_MOV:         w_res = r_s1_b;
      OP_BIC:         w_res = r_s1_a & ~r_s1_b;
      OP_MVN:         w_res = ~r_s1_b;
      OP_SUB, OP_CMP: begin w_arith = 1'b1; w_x = r_s1_a; w_y = ~r_s1_b; w_ci = 1'b1;     end
      OP_RSB:         begin w_arith = 1'b1; w_x = r_s1_b; w_y = ~r_s1_a; w_ci = 1'b1;     end
      OP_ADD, OP_CMN: begin w_arith = 1'b1; w_x = r_s1_a; w_y = r_s1_b;  w_ci = 1'b0;     end
      OP_ADC:         begin w_arith = 1'b1; w_x = r_s1_a; w_y = r_s1_b;  w_ci = r_s1_cin; end
      OP_SBC:         begin w_arith = 1'b1; w_x = r_s1_a; w_y = ~r_s1_b; w_ci = r_s1_cin; end
      OP_RSC:         begin w_arith = 1'b1; w_x = r_s1_b; w_y = ~r_s1_a; w_ci = r_s1_cin; end
      default: ;
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};
    if (w_arith) begin
      w_res = w_sum[WIDTH-1:0];
      w_c   = w_sum[WIDTH];
      w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    end
    if (w_s1_mul || r_s1_err) begin
      w_res = w_s1_mul ? r_s1_c : '0;
      w_c   = r_s1_cin;
      w_v   = r_s1_vin;
      w_wr  = w_s1_mul;
    end
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      r_s2_v      <= 1'b0;
      r_s2_out    <= '0;
      r_s2_n      <= 1'b0;
      r_s2_z      <= 1'b0;
      r_s2_c      <= 1'b0;
      r_s2_v_flag <= 1'b0;
      r_s2_wr     <= 1'b0;
      r_s2_err    <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_v      <= 1'b1;
      r_s2_out    <= w_res;
      r_s2_n      <= w_res[WIDTH-1];
      r_s2_z      <= (w_res == '0);
      r_s2_c      <= w_c;
      r_s2_v_flag <= w_v;
      r_s2_wr     <= w_wr;
      r_s2_err    <= r_s1_err;
    end else if (bus.out_ready) begin
      r_s2_v <= 1'b0;
    end
  end

  // Outputs read as zero during the reset cycle itself, not only after it
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !reset && r_s2_v;
  assign bus.out       = reset ? '0 : r_s2_out;
  assign bus.nout      = !reset && r_s2_n;
  assign bus.zout      = !reset && r_s2_z;
  assign bus.cout      = !reset && r_s2_c;
  assign bus.vout      = !reset && r_s2_v_flag;
  assign bus.wr        = !reset && r_s2_wr;
  assign bus.err       = !reset && r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_pipe : directed self-checking bench for alu_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_pipe_if #(.WIDTH(32), .SHW(8)) bus ();

  alu_pipe #(.WIDTH(32), .SHW(8), .MUL_EN(1)) dut (
    .CP    (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.mode      = MODE_ALU;
    bus.op        = OP_MOV;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.cin       = 1'b0;
    bus.vin       = 1'b0;
    bus.shift_op  = SH_LSL;
    bus.shift_num = '0;
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] o, input logic [31:0] a_v,
                       input logic [31:0] b_v, input logic [31:0] c_v, input logic ci,
                       input logic vi, input logic [2:0] so, input logic [7:0] sn);
    bus.in_valid  = 1'b1;
    bus.mode      = m;
    bus.op        = o;
    bus.a         = a_v;
    bus.b         = b_v;
    bus.c         = c_v;
    bus.cin       = ci;
    bus.vin       = vi;
    bus.shift_op  = so;
    bus.shift_num = sn;
  endtask

  // Issues one op into an empty pipe and returns in its cycle 2
  task automatic alu_op(input logic [1:0] m, input logic [3:0] o, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic ci, input logic vi,
                        input logic [2:0] so, input logic [7:0] sn);
    drive(m, o, a_v, b_v, 32'h0, ci, vi, so, sn);
    #1;
    tick();
    idle();
    tick();
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b expected 0", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if ({bus.out, bus.nout, bus.zout, bus.cout, bus.vout, bus.wr, bus.err} !== 38'h0)
      $display("FAIL reset_outputs got out=%h flags=%b%b%b%b%b%b expected all 0", bus.out,
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr, bus.err);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b expected 1", bus.in_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_add();
    drive(MODE_ALU, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, SH_LSL, 8'd0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL add_in_ready got %b expected 1", bus.in_ready);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_valid_cycle1 got %b expected 0", bus.out_valid);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL add_valid_cycle2 got %b expected 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out !== 32'h0) $display("FAIL add_out got %h expected 00000000", bus.out);
    else n_pass++;
    n_checks++;
    if ({bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== 5'b01101)
      $display("FAIL add_flags got nzcvw=%b%b%b%b%b expected 01101",
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
  endtask

  task automatic test_cmp_sub();
    alu_op(MODE_ALU, OP_CMP, 32'h8000_0000, 32'h1, 1'b0, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if (bus.out !== 32'h7FFF_FFFF) $display("FAIL cmp_out got %h expected 7fffffff", bus.out);
    else n_pass++;
    n_checks++;
    if ({bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== 5'b00110)
      $display("FAIL cmp_flags got nzcvw=%b%b%b%b%b expected 00110",
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    alu_op(MODE_ALU, OP_SUB, 32'h0, 32'h1, 1'b0, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if (bus.out !== 32'hFFFF_FFFF) $display("FAIL sub_out got %h expected ffffffff", bus.out);
    else n_pass++;
    n_checks++;
    if ({bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== 5'b10001)
      $display("FAIL sub_flags got nzcvw=%b%b%b%b%b expected 10001",
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    // 10 - 3 via RSB, no borrow so C=1
    alu_op(MODE_ALU, OP_RSB, 32'd3, 32'd10, 1'b0, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if ({bus.out, bus.cout} !== {32'd7, 1'b1})
      $display("FAIL rsb_out got %h c=%b expected 00000007 c=1", bus.out, bus.cout);
    else n_pass++;
    alu_op(MODE_ALU, OP_ADC, 32'd1, 32'd2, 1'b1, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if (bus.out !== 32'd4) $display("FAIL adc_out got %h expected 00000004", bus.out);
    else n_pass++;
  endtask

  task automatic test_shifter();
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h8000_0000, 1'b0, 1'b0, SH_ASR, 8'd40);
    n_checks++;
    if ({bus.out, bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== {32'hFFFF_FFFF, 5'b10101})
      $display("FAIL asr40 got %h nzcvw=%b%b%b%b%b expected ffffffff 10101", bus.out,
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h1, 1'b1, 1'b0, SH_RRX, 8'd7);
    n_checks++;
    if ({bus.out, bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== {32'h8000_0000, 5'b10101})
      $display("FAIL rrx got %h nzcvw=%b%b%b%b%b expected 80000000 10101", bus.out,
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h1, 1'b0, 1'b0, SH_LSL, 8'd32);
    n_checks++;
    if ({bus.out, bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== {32'h0, 5'b01101})
      $display("FAIL lsl32 got %h nzcvw=%b%b%b%b%b expected 00000000 01101", bus.out,
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h1234_5678, 1'b0, 1'b0, SH_ROR, 8'd36);
    n_checks++;
    if ({bus.out, bus.cout} !== {32'h8123_4567, 1'b1})
      $display("FAIL ror36 got %h c=%b expected 81234567 c=1", bus.out, bus.cout);
    else n_pass++;
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h8000_0001, 1'b0, 1'b0, SH_ROR, 8'd32);
    n_checks++;
    if ({bus.out, bus.cout} !== {32'h8000_0001, 1'b1})
      $display("FAIL ror32 got %h c=%b expected 80000001 c=1", bus.out, bus.cout);
    else n_pass++;
    // Logical op: V passes vin through, C is the shifter carry b[3]
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'hF0, 1'b1, 1'b1, SH_LSR, 8'd4);
    n_checks++;
    if ({bus.out, bus.cout, bus.vout} !== {32'hF, 2'b01})
      $display("FAIL lsr4 got %h c=%b v=%b expected 0000000f c=0 v=1", bus.out, bus.cout, bus.vout);
    else n_pass++;
    alu_op(MODE_ALU, OP_MOV, 32'h0, 32'h5, 1'b1, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if ({bus.out, bus.cout} !== {32'h5, 1'b1})
      $display("FAIL lsl0 got %h c=%b expected 00000005 c=1", bus.out, bus.cout);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] exp [4];
    ops = '{OP_AND, OP_EOR, OP_ORR, OP_BIC};
    exp = '{32'h0000_F000, 32'h0000_0FF0, 32'h0000_FFF0, 32'h0000_00F0};
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 4) drive(MODE_ALU, ops[cyc], 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 1'b0, SH_LSL, 8'd0);
      else idle();
      #1;
      if (cyc < 4) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc %0d got %b expected 1", cyc, bus.in_ready);
        else n_pass++;
      end
      if (cyc >= 2) begin
        n_checks++;
        if ({bus.out_valid, bus.out} !== {1'b1, exp[cyc-2]})
          $display("FAIL b2b_out cyc %0d got valid=%b out=%h expected valid=1 out=%h",
                   cyc, bus.out_valid, bus.out, exp[cyc-2]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          idx = 0;
    int          nrx = 0;
    logic        acc;
    logic [31:0] rx [8];
    for (int cyc = 0; cyc < 25; cyc++) begin
      bus.out_ready = (cyc >= 5);
      if (idx < 3) drive(MODE_ALU, OP_ADD, 32'(idx + 1), 32'(idx + 1), 32'h0, 1'b0, 1'b0, SH_LSL, 8'd0);
      else idle();
      #1;
      if (cyc == 2) begin
        n_checks++;
        if (idx !== 2) $display("FAIL bp_accepted got %0d expected 2", idx);
        else n_pass++;
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out} !== {2'b10, 32'd2})
          $display("FAIL bp_hold cyc %0d got valid=%b in_ready=%b out=%h expected 1 0 00000002",
                   cyc, bus.out_valid, bus.in_ready, bus.out);
        else n_pass++;
      end
      if (bus.out_valid && bus.out_ready && nrx < 8) begin
        rx[nrx] = bus.out;
        nrx++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    bus.out_ready = 1'b1;
    idle();
    n_checks++;
    if (nrx !== 3) $display("FAIL bp_count got %0d expected 3", nrx);
    else n_pass++;
    n_checks++;
    if (nrx < 3 || {rx[0], rx[1], rx[2]} !== {32'd2, 32'd4, 32'd6})
      $display("FAIL bp_order got %h %h %h expected 00000002 00000004 00000006", rx[0], rx[1], rx[2]);
    else n_pass++;
  endtask

  task automatic test_mla();
    int          ready_cyc = -1;
    int          n_out = 0;
    logic        pending;
    logic        acc;
    int          oc [4];
    logic [31:0] ov [4];
    drive(MODE_MLA, OP_ADD, 32'd7, 32'd6, 32'd100, 1'b0, 1'b0, SH_LSL, 8'd0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL mla_in_ready got %b expected 1", bus.in_ready);
    else n_pass++;
    tick();
    drive(MODE_ALU, OP_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, SH_LSL, 8'd0);
    pending = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (bus.out_valid && n_out < 4) begin
        oc[n_out] = cyc;
        ov[n_out] = bus.out;
        n_out++;
      end
      if (pending && bus.in_ready && ready_cyc < 0) ready_cyc = cyc;
      acc = pending && bus.in_ready;
      tick();
      if (acc) begin
        pending = 1'b0;
        idle();
      end
    end
    n_checks++;
    if (ready_cyc !== 34) $display("FAIL mla_ready_cycle got %0d expected 34", ready_cyc);
    else n_pass++;
    n_checks++;
    if (n_out !== 2) $display("FAIL mla_out_count got %0d expected 2", n_out);
    else n_pass++;
    n_checks++;
    if (n_out < 1 || oc[0] !== 34 || ov[0] !== 32'd142)
      $display("FAIL mla_result got cyc %0d out %h expected cyc 34 out 0000008e", oc[0], ov[0]);
    else n_pass++;
    n_checks++;
    if (n_out < 2 || oc[1] !== 36 || ov[1] !== 32'd2)
      $display("FAIL mla_follow got cyc %0d out %h expected cyc 36 out 00000002", oc[1], ov[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    int hits = 0;
    drive(MODE_MUL, OP_ADD, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0, SH_LSL, 8'd0);
    #1;
    tick();
    idle();
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out, bus.nout, bus.zout, bus.cout, bus.vout, bus.wr, bus.err} !== 40'h0)
      $display("FAIL midmul_reset_outputs got valid=%b ready=%b out=%h wr=%b expected all 0",
               bus.out_valid, bus.in_ready, bus.out, bus.wr);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL midmul_ready_after got %b expected 1", bus.in_ready);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) hits++;
    end
    n_checks++;
    if (hits !== 0) $display("FAIL midmul_no_result got %0d valid cycles expected 0", hits);
    else n_pass++;
  endtask

  task automatic test_err();
    alu_op(2'd3, OP_ADD, 32'd5, 32'd6, 1'b1, 1'b0, SH_LSL, 8'd0);
    n_checks++;
    if ({bus.out_valid, bus.err, bus.out} !== {2'b11, 32'h0})
      $display("FAIL mode3 got valid=%b err=%b out=%h expected 1 1 00000000",
               bus.out_valid, bus.err, bus.out);
    else n_pass++;
    n_checks++;
    if ({bus.nout, bus.zout, bus.cout, bus.vout, bus.wr} !== 5'b01100)
      $display("FAIL mode3_flags got nzcvw=%b%b%b%b%b expected 01100",
               bus.nout, bus.zout, bus.cout, bus.vout, bus.wr);
    else n_pass++;
    alu_op(MODE_ALU, OP_ADD, 32'd5, 32'd6, 1'b0, 1'b1, 3'd6, 8'd1);
    n_checks++;
    if ({bus.out_valid, bus.err, bus.out, bus.zout, bus.vout, bus.wr} !== {2'b11, 32'h0, 3'b110})
      $display("FAIL bad_shift got valid=%b err=%b out=%h z=%b v=%b wr=%b expected 1 1 00000000 1 1 0",
               bus.out_valid, bus.err, bus.out, bus.zout, bus.vout, bus.wr);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_cmp_sub();
    test_shifter();
    test_back_to_back();
    test_backpressure();
    test_mla();
    test_reset_mid_mul();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle miniARMv7 ALU.
- Combines the ARM operand-2 barrel shifter, the 16 data-processing opcodes and flag generation in a 2-stage valid/ready pipeline.
- Adds iterative MUL/MLA in one shared datapath.
- Sits between decode/register-read and writeback.

Parameters:
- WIDTH, 32, datapath width (>=8).
- SHW, 8, shift_num width.
- MUL_EN, 1, 1 = MUL/MLA supported; 0 = modes 1/2 flag err.

Ports:
- CP  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts this cycle.
- mode  in  2  0 ALU, 1 MUL, 2 MLA, 3 reserved.
- op  in  4  ARM opcode: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN (0..15).
- a  in  WIDTH  Rn (multiplicand in MUL/MLA).
- b  in  WIDTH  operand 2 before shift (multiplier in MUL/MLA).
- c  in  WIDTH  MLA accumuland.
- cin, vin  in  1 each  current C and V flags.
- shift_op  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 reserved.
- shift_num  in  SHW  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out  out  WIDTH  result.
- nout, zout, cout, vout  out  1 each  flags.
- wr  out  1  result is written back; 0 for TST/TEQ/CMP/CMN.
- err  out  1  reserved mode or shift_op.

Behaviour:
- Reset: synchronous, active-high. In the reset cycle all pipeline valids clear, FSM goes to IDLE, counter=0, and all outputs are 0 (in_ready=0). in_ready=1 from the cycle after reset deasserts. Reset mid-MUL or mid-stall discards all in-flight work with no output.
- Accept: in_valid & in_ready at an edge.
- in_ready = FSM==IDLE & (!s1_v | s1_adv); s1_adv = !s2_v | out_ready.
- Stage 1: registers a, c, shifted b, shifter carry, op, mode, cin, vin.
- Stage 2: registers result and flags.
- out and flags stay stable while out_valid & !out_ready.
- Latency, counting the accept cycle as cycle 0:
  - ALU: out_valid in cycle 2.
  - MUL/MLA: out_valid in cycle WIDTH+2.
- Results always emerge in acceptance order. Full throughput is 1 ALU op per cycle.
- Shifter, with n = shift_num; n==0 leaves b unchanged and carry = cin, except RRX:
  - LSL n<WIDTH: carry = b[WIDTH-n]. n==WIDTH: 0, carry b[0]. n>WIDTH: 0, carry 0.
  - LSR n<WIDTH: carry = b[n-1]. n==WIDTH: 0, carry b[WIDTH-1]. n>WIDTH: 0, carry 0.
  - ASR n>=WIDTH: all bits = b[WIDTH-1], carry = b[WIDTH-1].
  - ROR: rotate by n mod WIDTH; carry = result[WIDTH-1]. n a nonzero multiple of WIDTH: b unchanged, carry = b[WIDTH-1].
  - RRX: {cin, b[WIDTH-1:1]}, carry = b[0]; shift_num ignored.
  - Reserved shift_op: b unchanged, err=1.
- Arithmetic (SUB RSB ADD ADC SBC RSC CMP CMN):
  - (WIDTH+1)-bit add, with subtraction as x + ~y + 1 (SBC/RSC use cin in place of 1).
  - cout = carry out, so ARM "no borrow" gives C=1.
  - vout = signed overflow.
- Logical ops: cout = shifter carry; vout = vin.
- nout = out[WIDTH-1]; zout = (out==0).
- MUL/MLA FSM: IDLE -> MUL on acceptance of mode 1/2.
  - Shift-add: acc is initialised to 0 (MUL) or c (MLA). In each of the WIDTH cycles, if multiplier bit[0] is set, add the multiplicand; then shift the multiplicand left and the multiplier right.
  - When the counter reaches WIDTH the FSM enters DONE. DONE -> IDLE when the result transfers to s2 (waits while s2 is full and !out_ready).
  - Result = low WIDTH bits. Flags: N,Z from result; cout=cin; vout=vin. wr=1.
- err cases produce out=0, wr=0, and flags cin/vin with N=0, Z=1.
- Both err cases pass through with ALU latency: mode 3, and mode 1/2 with MUL_EN=0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_AND..OP_MVN.
  - shift localparams: SH_LSL..SH_RRX.
  - mode localparams: MODE_ALU, MODE_MUL, MODE_MLA.
  - FSM state encoding: IDLE, MUL, DONE.
  - helper predicate is_test(op), true for op 8..11.
- One sub-module, barrel_shifter: combinational, parametrised WIDTH/SHW, outputs value and carry. It is the only instance.

Test Plan:
- ADD (op 4) a=0xFFFFFFFF b=1 LSL #0 cin=0 -> out 0, z=1 c=1 n=0 v=0 wr=1, out_valid exactly cycle 2.
- CMP (op 10) a=0x80000000 b=1 -> out 0x7FFFFFFF, wr=0, n=0 z=0 c=1 v=1. Then SUB a=0 b=1 -> 0xFFFFFFFF, n=1 c=0 v=0.
- MOV (op 13) b=0x80000000:
  - ASR shift_num=40 -> 0xFFFFFFFF, c=1.
  - RRX b=1 cin=1 -> 0x80000000, c=1.
  - LSL shift_num=32 b=1 -> 0, c=1, z=1.
- MLA a=7 b=6 c=100 accepted cycle 0, ADD 1+1 presented cycle 1 -> in_ready=0 until the MLA result leaves stage 1. Out 142 in cycle 34, then out 2; order preserved.
- out_ready=0 for 5 cycles while ADDs 1+1, 2+2, 3+3 are streamed -> two accepted, then in_ready=0. Output held at 2 until released, then 2, 4, 6 in order, no loss or duplication.
- Reset asserted in cycle 10 of a MUL -> outputs 0 that cycle, no result ever appears, in_ready=1 the next cycle. mode=3 -> err=1, out=0, wr=0 at cycle 2.
